fwd_hazard_tag_pipe: RTL

//   Parametrised successor to the single-pair register-number equality compare.

---
 rtl/fwd_hazard_tag_pipe.sv | 104 ++++++++++
 1 files changed

// File: rtl/fwd_hazard_tag_pipe.sv
// Destination-tag tracker for in-flight writes (EX/MEM/WB). Compares each issuing
// source against every tracked tag, giving youngest-first forwarding selects and a load-use stall.
module fwd_hazard_tag_pipe #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int NUM_SRC  = 2,
  parameter int ZERO_REG = 31,
  localparam int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      issue_valid,
  input  logic                      issue_wr_en,
  input  logic [ADDR_W-1:0]         issue_rd,
  input  logic                      issue_load,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic                      freeze,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      hazard_stall
);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_wr_en;
  logic [DEPTH-1:0]  r_load;
  logic [ADDR_W-1:0] r_rd [DEPTH];

  logic [NUM_SRC-1:0][DEPTH-1:0] w_match;
  logic [NUM_SRC-1:0]            w_match_e0;
  logic                          w_stall;

  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_match[k][i] = r_valid[i] & r_wr_en[i] & src_used[k]
                      & (r_rd[i] == src_addr[k*ADDR_W +: ADDR_W])
                      & (src_addr[k*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG));
      end
    end
  end

  // Scan oldest to youngest so the youngest matching entry overwrites last.
  always_comb begin
    fwd_sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (w_match[k][i]) begin
          fwd_sel[k*SEL_W +: SEL_W] = SEL_W'(i + 1);
        end
      end
    end
  end

  always_comb begin
    w_match_e0 = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_match_e0[k] = w_match[k][0];
    end
  end

  // Only a load still in EX is too late to forward; older loads have their data.
  assign w_stall      = issue_valid & ~flush & r_load[0] & (|w_match_e0);
  assign hazard_stall = w_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      r_wr_en <= '0;
      r_load  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i] <= '0;
      end
    end else if (freeze) begin
      if (flush) begin
        r_valid[0] <= 1'b0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_wr_en[i] <= r_wr_en[i-1];
        r_load[i]  <= r_load[i-1];
        r_rd[i]    <= r_rd[i-1];
      end
      // A flushed EX entry only reaches MEM as a bubble, so both cases clear e0 here
      // and the flush additionally drops the shifted copy below.
      if (flush || w_stall) begin
        r_valid[0] <= 1'b0;
        r_wr_en[0] <= 1'b0;
        r_load[0]  <= 1'b0;
        r_rd[0]    <= '0;
      end else begin
        r_valid[0] <= issue_valid;
        r_wr_en[0] <= issue_wr_en;
        r_load[0]  <= issue_load;
        r_rd[0]    <= issue_rd;
      end
      if (flush && DEPTH > 1) begin
        r_valid[1 % DEPTH] <= 1'b0;
      end
    end
  end

endmodule
